mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 InstrM  input  32  M-stage instruction.
REQ-004 PcM  input  32  M-stage PC.
REQ-005 ALUOutM  input  32  M-stage ALU result; byte address for loads and stores.
REQ-006 WriteDataM  input  32  M-stage store data.
REQ-007 WriteRegM  input  5  M-stage destination register.
REQ-008 RegWriteM  input  1  M-stage register-write enable.
REQ-009 MemtoRegM  input  1  M-stage load select.
REQ-010 T_new_M  input  2  M-stage cycles-until-result counter.
REQ-011 jal_selM  input  1  M-stage link-write flag.
REQ-012 InstrW, PcW, ALUOutW  output  32 each  registered copies of the M-stage values.
REQ-013 ReadDataW  output  32  registered, extended load data.
REQ-014 WriteRegW  output  5  registered; RegWriteW, MemtoRegW, jal_selW  output  1 each  registered.
REQ-015 T_new_W  output  2  registered counter.

Function
REQ-016 Data memory SHALL be 4096 x 32-bit words, indexed by ALUOutM[13:2]; ALUOutM[31:14] SHALL be ignored, so higher addresses wrap.
REQ-017 Opcode SHALL be InstrM[31:26], decoded as follows:
- stores: sw=101011, sh=101001, sb=101000
- loads: lw=100011, lh=100001, lhu=100101, lb=100000, lbu=100100
- any other opcode is neither a load nor a store.
REQ-018 sw SHALL write the full word on the rising edge; ALUOutM[1:0] is ignored.
REQ-019 sh SHALL write WriteDataM[15:0] to halfword ALUOutM[1] (0 = bits 15:0, 1 = bits 31:16) and leave the other halfword unchanged; ALUOutM[0] is ignored.
REQ-020 sb SHALL write WriteDataM[7:0] to byte lane ALUOutM[1:0] (lane 0 = bits 7:0) and leave the other bytes unchanged.
REQ-021 Loads SHALL read the addressed word combinationally from current memory contents and select the byte/halfword lane as in REQ-019/REQ-020.
REQ-022 Load extension: lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word. The result SHALL register into ReadDataW with 1-cycle latency.
REQ-023 When InstrM is not a load, ReadDataW SHALL register 0.
REQ-024 A store in cycle N SHALL be visible to a load to the same address in cycle N+1 (read-after-write through memory, no bypass needed).
REQ-025 Each rising edge without reset SHALL register the following:
- InstrW<=InstrM, PcW<=PcM, ALUOutW<=ALUOutM
- WriteRegW<=WriteRegM, RegWriteW<=RegWriteM, MemtoRegW<=MemtoRegM, jal_selW<=jal_selM
REQ-026 T_new_W SHALL register (T_new_M>0) ? T_new_M-1 : 0; it never underflows.
REQ-027 RegWriteM and WriteRegM SHALL have no effect on memory; only the store opcode enables writes.

Reset
REQ-028 On a reset edge, all registered outputs SHALL become 0 (including T_new_W=2'b00).
REQ-029 On a reset edge, every memory word SHALL be cleared to 0.
REQ-030 A store presented on a reset edge SHALL NOT write; the clear takes precedence.
REQ-031 Reset asserted mid-sequence SHALL discard any in-flight load result; ReadDataW=0 on the following cycle.

Verification
REQ-032 Reset, then lw at 0x0000_0010 -> ReadDataW=0x0000_0000; all W outputs 0 during reset.
REQ-033 sw 0x8765_43A1 to 0x20, then next cycle lb 0x20 -> ReadDataW=0xFFFF_FFA1; lbu 0x23 -> 0x0000_0087; lh 0x22 -> 0xFFFF_8765; lhu 0x20 -> 0x0000_43A1.
REQ-034 Word 0x40 = 0x1111_1111, then sb 0xAB to 0x41 -> lw 0x40 returns 0x1111_AB11; then sh 0xCDEF to 0x42 -> lw returns 0xCDEF_AB11.
REQ-035 sw 0x5A5A_5A5A to 0x0000_4004, then lw 0x0000_0004 -> 0x5A5A_5A5A (address wrap).
REQ-036 Drive T_new_M=3,2,1,0 on successive cycles -> T_new_W=2,1,0,0; PcM/InstrM/WriteRegM appear on W outputs one cycle later.
REQ-037 Store issued on the same edge as reset, then lw to that address after reset deasserts -> ReadDataW=0.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// M-to-W pipeline bus: M-stage values in, registered W-stage values out.
// The driver of the M side uses master; the stage itself uses slave.
interface mem_wb_stage_if;
  logic [31:0] InstrM;
  logic [31:0] PcM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic        RegWriteM;
  logic        MemtoRegM;
  logic [1:0]  T_new_M;
  logic        jal_selM;

  logic [31:0] InstrW;
  logic [31:0] PcW;
  logic [31:0] ALUOutW;
  logic [31:0] ReadDataW;
  logic [4:0]  WriteRegW;
  logic        RegWriteW;
  logic        MemtoRegW;
  logic [1:0]  T_new_W;
  logic        jal_selW;

  modport master (
    output InstrM, PcM, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, T_new_M, jal_selM,
    input  InstrW, PcW, ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW, T_new_W, jal_selW
  );

  modport slave (
    input  InstrM, PcM, ALUOutM, WriteDataM, WriteRegM, RegWriteM, MemtoRegM, T_new_M, jal_selM,
    output InstrW, PcW, ALUOutW, ReadDataW, WriteRegW, RegWriteW, MemtoRegW, T_new_W, jal_selW
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: 4096-word data memory with byte/halfword stores,
// combinational load read with extension, and the M-to-W pipeline registers.
module mem_wb_stage (
  input  logic           clk,
  input  logic           reset,
  mem_wb_stage_if.slave  bus
);
  localparam int DEPTH = 4096;

  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;

  logic [5:0]  opcode;
  logic [11:0] word_idx;
  logic [1:0]  lane;

  assign opcode   = bus.InstrM[31:26];
  assign word_idx = bus.ALUOutM[13:2];
  assign lane     = bus.ALUOutM[1:0];

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_word;

  assign rd_word = mem_q[word_idx];

  // Stores become a read-modify-write of the addressed word under a byte mask.
  logic [3:0]  be;
  logic [31:0] wr_lanes;
  logic [31:0] wr_word;

  always_comb begin
    be       = 4'b0000;
    wr_lanes = bus.WriteDataM;
    case (opcode)
      OP_SW: be = 4'b1111;
      OP_SH: begin
        be       = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{bus.WriteDataM[15:0]}};
      end
      OP_SB: begin
        be       = 4'b0001 << lane;
        wr_lanes = {4{bus.WriteDataM[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_word[8*gi +: 8] = be[gi] ? wr_lanes[8*gi +: 8] : rd_word[8*gi +: 8];
    end
  endgenerate

  // Reset clears every word and wins over a store on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (|be) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] rd_data_d;

  assign ld_byte = rd_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_data_d = '0;
    case (opcode)
      OP_LW:   rd_data_d = rd_word;
      OP_LH:   rd_data_d = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  rd_data_d = {16'h0000, ld_half};
      OP_LB:   rd_data_d = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  rd_data_d = {24'h000000, ld_byte};
      default: rd_data_d = '0;
    endcase
  end

  logic [1:0] t_new_d;
  assign t_new_d = (bus.T_new_M != 2'd0) ? bus.T_new_M - 2'd1 : 2'd0;

  logic [31:0] instr_q, pc_q, alu_out_q, rd_data_q;
  logic [4:0]  write_reg_q;
  logic        reg_write_q, mem_to_reg_q, jal_sel_q;
  logic [1:0]  t_new_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q      <= '0;
      pc_q         <= '0;
      alu_out_q    <= '0;
      rd_data_q    <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      jal_sel_q    <= 1'b0;
      t_new_q      <= 2'd0;
    end else begin
      instr_q      <= bus.InstrM;
      pc_q         <= bus.PcM;
      alu_out_q    <= bus.ALUOutM;
      rd_data_q    <= rd_data_d;
      write_reg_q  <= bus.WriteRegM;
      reg_write_q  <= bus.RegWriteM;
      mem_to_reg_q <= bus.MemtoRegM;
      jal_sel_q    <= bus.jal_selM;
      t_new_q      <= t_new_d;
    end
  end

  assign bus.InstrW    = instr_q;
  assign bus.PcW       = pc_q;
  assign bus.ALUOutW   = alu_out_q;
  assign bus.ReadDataW = rd_data_q;
  assign bus.WriteRegW = write_reg_q;
  assign bus.RegWriteW = reg_write_q;
  assign bus.MemtoRegW = mem_to_reg_q;
  assign bus.jal_selW  = jal_sel_q;
  assign bus.T_new_W   = t_new_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a word-array reference model checked every cycle,
// directed literal cases, then randomized traffic with occasional resets.
module tb_mem_wb_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  mem_wb_stage_if bus ();

  mem_wb_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
  localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
  localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
  localparam logic [5:0] NOP = 6'b000000, ADDI = 6'b001000;

  // Reference memory as plain words; lanes handled with shifts and masks.
  logic [31:0] model_mem [4096];
  logic [31:0] e_instr, e_pc, e_alu, e_rd;
  logic [4:0]  e_wreg;
  logic        e_rw, e_m2r, e_jal;
  logic [1:0]  e_t;
  bit          model_valid = 1'b0;

  function automatic logic [31:0] load_result(logic [5:0] op, logic [31:0] word, logic [1:0] off);
    logic [31:0] b, h;
    b = (word >> (8 * off)) & 32'hFF;
    h = (word >> (16 * off[1])) & 32'hFFFF;
    case (op)
      LW:      return word;
      LBU:     return b;
      LB:      return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      LHU:     return h;
      LH:      return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] store_result(logic [5:0] op, logic [31:0] old, logic [31:0] data,
                                               logic [1:0] off);
    logic [31:0] mask;
    case (op)
      SW:      return data;
      SH: begin
        mask = 32'hFFFF << (16 * off[1]);
        return (old & ~mask) | ((data & 32'hFFFF) << (16 * off[1]));
      end
      SB: begin
        mask = 32'hFF << (8 * off);
        return (old & ~mask) | ((data & 32'hFF) << (8 * off));
      end
      default: return old;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      e_instr <= '0; e_pc <= '0; e_alu <= '0; e_rd <= '0;
      e_wreg <= '0; e_rw <= 1'b0; e_m2r <= 1'b0; e_jal <= 1'b0; e_t <= 2'd0;
      for (int i = 0; i < 4096; i++) model_mem[i] <= '0;
      model_valid <= 1'b1;
    end else begin
      e_instr <= bus.InstrM;
      e_pc    <= bus.PcM;
      e_alu   <= bus.ALUOutM;
      e_wreg  <= bus.WriteRegM;
      e_rw    <= bus.RegWriteM;
      e_m2r   <= bus.MemtoRegM;
      e_jal   <= bus.jal_selM;
      e_t     <= (bus.T_new_M > 2'd0) ? bus.T_new_M - 2'd1 : 2'd0;
      e_rd    <= load_result(bus.InstrM[31:26], model_mem[bus.ALUOutM[13:2]], bus.ALUOutM[1:0]);
      model_mem[bus.ALUOutM[13:2]] <= store_result(bus.InstrM[31:26], model_mem[bus.ALUOutM[13:2]],
                                                   bus.WriteDataM, bus.ALUOutM[1:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      chk("InstrW", bus.InstrW, e_instr);
      chk("PcW", bus.PcW, e_pc);
      chk("ALUOutW", bus.ALUOutW, e_alu);
      chk("ReadDataW", bus.ReadDataW, e_rd);
      chk("WriteRegW", {27'd0, bus.WriteRegW}, {27'd0, e_wreg});
      chk("RegWriteW", {31'd0, bus.RegWriteW}, {31'd0, e_rw});
      chk("MemtoRegW", {31'd0, bus.MemtoRegW}, {31'd0, e_m2r});
      chk("jal_selW", {31'd0, bus.jal_selW}, {31'd0, e_jal});
      chk("T_new_W", {30'd0, bus.T_new_W}, {30'd0, e_t});
    end
  end

  int txn = 0;

  task automatic step(input logic rst, input logic [5:0] opc, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [1:0] tn, input logic [31:0] pc);
    logic [31:0] r;
    r = $urandom();
    reset          = rst;
    bus.InstrM     = {opc, r[25:0]};
    bus.PcM        = pc;
    bus.ALUOutM    = addr;
    bus.WriteDataM = wd;
    bus.WriteRegM  = r[30:26];
    bus.RegWriteM  = r[31];
    bus.MemtoRegM  = r[0];
    bus.jal_selM   = r[1];
    bus.T_new_M    = tn;
    @(posedge clk);
    #1;
    $display("txn %0d rst=%0b op=%b addr=%h wd=%h tnew=%0d -> rd=%h tW=%0d",
             txn, rst, opc, addr, wd, tn, bus.ReadDataW, bus.T_new_W);
    txn++;
  endtask

  logic [5:0] op_table [10];

  initial begin
    logic [31:0] r, a;
    op_table = '{SW, SH, SB, LW, LH, LHU, LB, LBU, NOP, ADDI};

    // Store presented during reset must be discarded.
    step(1'b1, SW, 32'h80, 32'hDEAD_BEEF, 2'd3, 32'h1234);
    step(1'b1, SW, 32'h80, 32'hDEAD_BEEF, 2'd3, 32'h1234);
    chk("rst_InstrW", bus.InstrW, 32'h0);
    chk("rst_PcW", bus.PcW, 32'h0);
    chk("rst_T_new_W", {30'd0, bus.T_new_W}, 32'h0);
    chk("rst_ReadDataW", bus.ReadDataW, 32'h0);

    step(1'b0, LW, 32'h10, 32'h0, 2'd0, 32'h0);
    chk("lw_after_reset", bus.ReadDataW, 32'h0);
    step(1'b0, LW, 32'h80, 32'h0, 2'd0, 32'h0);
    chk("lw_store_on_reset", bus.ReadDataW, 32'h0);

    step(1'b0, SW, 32'h20, 32'h8765_43A1, 2'd0, 32'h0);
    step(1'b0, LB, 32'h20, 32'h0, 2'd0, 32'h0);
    chk("lb_0x20", bus.ReadDataW, 32'hFFFF_FFA1);
    step(1'b0, LBU, 32'h23, 32'h0, 2'd0, 32'h0);
    chk("lbu_0x23", bus.ReadDataW, 32'h0000_0087);
    step(1'b0, LH, 32'h22, 32'h0, 2'd0, 32'h0);
    chk("lh_0x22", bus.ReadDataW, 32'hFFFF_8765);
    step(1'b0, LHU, 32'h20, 32'h0, 2'd0, 32'h0);
    chk("lhu_0x20", bus.ReadDataW, 32'h0000_43A1);
    step(1'b0, ADDI, 32'h20, 32'h0, 2'd0, 32'h0);
    chk("nonload_zero", bus.ReadDataW, 32'h0);

    step(1'b0, SW, 32'h40, 32'h1111_1111, 2'd0, 32'h0);
    step(1'b0, SB, 32'h41, 32'hFFFF_FFAB, 2'd0, 32'h0);
    step(1'b0, LW, 32'h40, 32'h0, 2'd0, 32'h0);
    chk("sb_merge", bus.ReadDataW, 32'h1111_AB11);
    step(1'b0, SH, 32'h42, 32'h0000_CDEF, 2'd0, 32'h0);
    step(1'b0, LW, 32'h40, 32'h0, 2'd0, 32'h0);
    chk("sh_merge", bus.ReadDataW, 32'hCDEF_AB11);

    step(1'b0, SW, 32'h0000_4004, 32'h5A5A_5A5A, 2'd0, 32'h0);
    step(1'b0, LW, 32'h0000_0004, 32'h0, 2'd0, 32'h0);
    chk("addr_wrap", bus.ReadDataW, 32'h5A5A_5A5A);

    step(1'b0, NOP, 32'h0, 32'h0, 2'd3, 32'h100);
    chk("tnew_3", {30'd0, bus.T_new_W}, 32'd2);
    chk("pc_100", bus.PcW, 32'h100);
    step(1'b0, NOP, 32'h0, 32'h0, 2'd2, 32'h104);
    chk("tnew_2", {30'd0, bus.T_new_W}, 32'd1);
    step(1'b0, NOP, 32'h0, 32'h0, 2'd1, 32'h108);
    chk("tnew_1", {30'd0, bus.T_new_W}, 32'd0);
    step(1'b0, NOP, 32'h0, 32'h0, 2'd0, 32'h10C);
    chk("tnew_0", {30'd0, bus.T_new_W}, 32'd0);
    chk("pc_10c", bus.PcW, 32'h10C);

    // Random traffic confined to a few words so loads hit earlier stores;
    // upper address bits stay random to exercise wrap.
    for (int n = 0; n < 1500; n++) begin
      r = $urandom();
      a = {r[31:14], 8'd0, r[5:0]};
      step(($urandom_range(0, 63) == 0), op_table[$urandom_range(0, 9)], a, $urandom(),
           2'($urandom_range(0, 3)), $urandom());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
